// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter: merges pipeline writes with a one-entry buffered divider result.
// Optional stale-drop / forced-grant statistics are enabled with the WB_ARB_STAT_EN macro.
module regfile_wb_arb #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_hold,
    input  logic        div_valid,
    input  logic [4:0]  div_waddr,
    input  logic [31:0] div_wdata,
    output logic        div_ready,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic        rd_stall,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
`ifdef WB_ARB_STAT_EN
    ,
    output logic [15:0] drop_cnt,
    output logic [15:0] force_cnt
`endif
);

    localparam logic [2:0] WAIT_MAX = 3'(STARVE_MAX);

    typedef enum logic [1:0] {GNT_NONE, GNT_BUF, GNT_PIPE, GNT_DIV} grant_t;

    grant_t      grant;
    logic        buf_valid, buf_valid_nxt;
    logic [4:0]  buf_addr, buf_addr_nxt;
    logic [31:0] buf_data, buf_data_nxt;
    logic [2:0]  wait_cnt, wait_nxt;
    logic        pipe_req, div_xfer, forced, stale_drop;

    assign div_ready = rst && !buf_valid;
    assign pipe_hold = forced;
    assign rd_stall  = buf_valid && (buf_addr != '0) &&
                       ((re1 && (raddr1 == buf_addr)) || (re2 && (raddr2 == buf_addr)));

    always_comb begin
        pipe_req = pipe_we && (pipe_waddr != '0);
        div_xfer = div_valid && div_ready;
        forced   = buf_valid && (wait_cnt == WAIT_MAX);
        grant    = GNT_NONE;
        if (forced)
            grant = GNT_BUF;
        else if (pipe_req)
            grant = GNT_PIPE;
        else if (buf_valid)
            grant = GNT_BUF;
        else if (div_xfer && (div_waddr != '0))
            grant = GNT_DIV;
    end

    // A divider result only reaches the buffer when it lost to a pipeline write to a different register.
    always_comb begin
        buf_valid_nxt = buf_valid;
        buf_addr_nxt  = buf_addr;
        buf_data_nxt  = buf_data;
        wait_nxt      = '0;
        stale_drop    = 1'b0;
        if (grant == GNT_BUF) begin
            buf_valid_nxt = 1'b0;
        end else if (buf_valid) begin
            if ((grant == GNT_PIPE) && (pipe_waddr == buf_addr)) begin
                buf_valid_nxt = 1'b0;
                stale_drop    = 1'b1;
            end else begin
                wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 3'd1;
            end
        end else if (div_xfer && (div_waddr != '0) && (grant == GNT_PIPE)) begin
            if (pipe_waddr == div_waddr) begin
                stale_drop = 1'b1;
            end else begin
                buf_valid_nxt = 1'b1;
                buf_addr_nxt  = div_waddr;
                buf_data_nxt  = div_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            wait_cnt  <= '0;
        end else begin
            buf_valid <= buf_valid_nxt;
            buf_addr  <= buf_addr_nxt;
            buf_data  <= buf_data_nxt;
            wait_cnt  <= wait_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= (grant != GNT_NONE);
            case (grant)
                GNT_BUF: begin
                    waddr <= buf_addr;
                    wdata <= buf_data;
                end
                GNT_PIPE: begin
                    waddr <= pipe_waddr;
                    wdata <= pipe_wdata;
                end
                GNT_DIV: begin
                    waddr <= div_waddr;
                    wdata <= div_wdata;
                end
                default: begin
                    waddr <= waddr;
                    wdata <= wdata;
                end
            endcase
        end
    end

`ifdef WB_ARB_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt  <= '0;
            force_cnt <= '0;
        end else begin
            if (stale_drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 16'd1;
            if (forced && (force_cnt != '1))
                force_cnt <= force_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Self-checking bench for regfile_wb_arb: directed scenarios then random traffic against a behavioural model.
// Statistic outputs are checked when WB_ARB_STAT_EN is defined.
module tb_regfile_wb_arb;

    localparam int unsigned STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_hold;
    logic        div_valid;
    logic [4:0]  div_waddr;
    logic [31:0] div_wdata;
    logic        div_ready;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic        rd_stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef WB_ARB_STAT_EN
    logic [15:0] drop_cnt, force_cnt;
`endif

    regfile_wb_arb #(.STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata), .pipe_hold(pipe_hold),
        .div_valid(div_valid), .div_waddr(div_waddr), .div_wdata(div_wdata), .div_ready(div_ready),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2), .rd_stall(rd_stall),
        .we(we), .waddr(waddr), .wdata(wdata)
`ifdef WB_ARB_STAT_EN
        , .drop_cnt(drop_cnt), .force_cnt(force_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: pending divider entry, its age, and the expected write port.
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    int unsigned mw;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    int unsigned mdrop, mforce;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv = 1'b0; ma = '0; md = '0; mw = 0;
        ewe = 1'b0; ewa = '0; ewd = '0;
        mdrop = 0; mforce = 0;
    endtask

    task automatic idle();
        pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        div_valid = 1'b0; div_waddr = '0; div_wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    endtask

    task automatic emit(input logic [4:0] a, input logic [31:0] d);
        ewe = 1'b1; ewa = a; ewd = d;
    endtask

    // One clock: check combinational outputs, predict the write, then check it after the edge.
    task automatic step();
        logic exp_ready, exp_forced, exp_stall, preq, xfer;
        #1;
        exp_ready  = rst && !mv;
        exp_forced = mv && (mw == STARVE);
        exp_stall  = mv && (ma != 0) && ((re1 && raddr1 == ma) || (re2 && raddr2 == ma));
        check("div_ready", div_ready, exp_ready);
        check("pipe_hold", pipe_hold, exp_forced);
        check("rd_stall", rd_stall, exp_stall);
        preq = pipe_we && (pipe_waddr != 0);
        xfer = div_valid && exp_ready;
        ewe  = 1'b0;
        if (exp_forced) begin
            emit(ma, md); mv = 1'b0; mforce++;
        end else if (preq) begin
            emit(pipe_waddr, pipe_wdata);
            if (mv && pipe_waddr == ma) begin
                mv = 1'b0; mdrop++;
            end else if (mv) begin
                if (mw < STARVE) mw++;
            end else if (xfer && div_waddr != 0) begin
                if (div_waddr == pipe_waddr) mdrop++;
                else begin mv = 1'b1; ma = div_waddr; md = div_wdata; mw = 0; end
            end
        end else if (mv) begin
            emit(ma, md); mv = 1'b0;
        end else if (xfer && div_waddr != 0) begin
            emit(div_waddr, div_wdata);
        end
        if (!mv) mw = 0;
        @(posedge clk); #1;
        check("we", we, ewe);
        check("waddr", waddr, ewa);
        check("wdata", wdata, ewd);
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", we, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_div_ready", div_ready, 0);
        check("rst_pipe_hold", pipe_hold, 0);
        check("rst_rd_stall", rd_stall, 0);
        rst = 1'b1;

        // Bypass with idle pipeline
        div_valid = 1'b1; div_waddr = 5'd5; div_wdata = 32'h1234;
        step();
        check("byp_waddr", waddr, 5);
        check("byp_wdata", wdata, 32'h1234);
        idle();
        step();
        check("byp_buf_empty", div_ready, 1);

        // Buffering behind a pipeline write, then drain
        pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h0333;
        div_valid = 1'b1; div_waddr = 5'd7; div_wdata = 32'h0777;
        step();
        check("buf_first_waddr", waddr, 3);
        idle();
        re1 = 1'b1; raddr1 = 5'd7;
        #1;
        check("buf_rd_stall", rd_stall, 1);
        check("buf_div_ready", div_ready, 0);
        step();
        check("buf_drain_waddr", waddr, 7);
        check("buf_drain_wdata", wdata, 32'h0777);
        idle();
        step();

        // Starvation: continuous pipeline traffic to r2 while r9 waits
        pipe_we = 1'b1; pipe_waddr = 5'd2; pipe_wdata = 32'h0222;
        div_valid = 1'b1; div_waddr = 5'd9; div_wdata = 32'h9999;
        step();
        div_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            #1;
            check("starve_hold", pipe_hold, (i == 5) ? 1 : 0);
            step();
            check("starve_waddr", waddr, (i == 5) ? 9 : 2);
        end
        idle();
        step();

        // Stale drop: pipeline overwrites the buffered register
        pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h0111;
        div_valid = 1'b1; div_waddr = 5'd4; div_wdata = 32'hAAAA;
        step();
        div_valid = 1'b0;
        pipe_waddr = 5'd4; pipe_wdata = 32'hBBBB;
        step();
        check("stale_wdata", wdata, 32'hBBBB);
        idle();
        step();
        check("stale_no_late_write", we, 0);
`ifdef WB_ARB_STAT_EN
        check("stale_drop_cnt", drop_cnt, mdrop[15:0]);
        check("force_cnt", force_cnt, mforce[15:0]);
`endif

        // Asynchronous reset with r6 buffered
        pipe_we = 1'b1; pipe_waddr = 5'd1; pipe_wdata = 32'h0101;
        div_valid = 1'b1; div_waddr = 5'd6; div_wdata = 32'h0666;
        step();
        idle();
        re1 = 1'b1; raddr1 = 5'd6;
        #3;
        check("pre_rst_stall", rd_stall, 1);
        rst = 1'b0;
        #1;
        check("arst_we", we, 0);
        check("arst_waddr", waddr, 0);
        check("arst_wdata", wdata, 0);
        check("arst_div_ready", div_ready, 0);
        check("arst_pipe_hold", pipe_hold, 0);
        check("arst_rd_stall", rd_stall, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_write", we, 0);
        end

        // Zero destination addresses
        pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hDEAD;
        div_valid = 1'b1; div_waddr = 5'd0; div_wdata = 32'hBEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            check("zero_we", we, 0);
            check("zero_div_ready", div_ready, 1);
        end

        // Random traffic over a narrow address range to provoke collisions and starvation
        for (int i = 0; i < 400; i++) begin
            pipe_we    = ($urandom_range(3) != 0);
            pipe_waddr = 5'($urandom_range(7));
            pipe_wdata = $urandom;
            div_valid  = $urandom_range(1);
            div_waddr  = 5'($urandom_range(7));
            div_wdata  = $urandom;
            re1 = $urandom_range(1); raddr1 = 5'($urandom_range(7));
            re2 = $urandom_range(1); raddr2 = 5'($urandom_range(7));
            step();
        end
        idle();
        step();
`ifdef WB_ARB_STAT_EN
        check("rand_drop_cnt", drop_cnt, mdrop[15:0]);
        check("rand_force_cnt", force_cnt, mforce[15:0]);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter: STARVE_MAX, default 4, number of cycles a buffered divider result may lose arbitration before it is forced through (range 1..7).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-004 pipe_we  in  1  pipeline writeback enable.
REQ-005 pipe_waddr  in  5  pipeline destination register.
REQ-006 pipe_wdata  in  32  pipeline writeback data.
REQ-007 pipe_hold  out  1  pipeline must hold its writeback unchanged next cycle.
REQ-008 div_valid  in  1  divider result valid.
REQ-009 div_waddr  in  5  divider destination register.
REQ-010 div_wdata  in  32  divider result.
REQ-011 div_ready  out  1  arbiter can accept a divider result.
REQ-012 re1/raddr1, re2/raddr2  in  1/5 each  decode-stage read requests, monitored for hazards.
REQ-013 rd_stall  out  1  a read targets a register with a pending buffered write.
REQ-014 we, waddr, wdata  out  1/5/32  registered write port driving the register file.

Function
REQ-015 The block SHALL hold a one-entry buffer (buf_valid, buf_addr, buf_data) and a 3-bit wait counter wait_cnt.
REQ-016 div_ready SHALL equal !buf_valid while rst is high, and 0 while rst is low; a divider transfer occurs when div_valid && div_ready.
REQ-017 Grant priority per cycle, highest first: (a) forced = buf_valid && wait_cnt==STARVE_MAX -> buffer; (b) pipe_we && pipe_waddr!=0 -> pipeline; (c) buf_valid -> buffer; (d) divider transfer in progress (bypass) -> divider; (e) none.
REQ-018 pipe_hold SHALL equal forced (combinational); when asserted the pipeline write is not granted that cycle.
REQ-019 The granted write SHALL appear on we/waddr/wdata exactly one cycle later; with no grant, we=0 and waddr/wdata hold their previous values.
REQ-020 A divider transfer not bypassed under (d) SHALL load the buffer; a bypassed transfer leaves the buffer empty.
REQ-021 A divider transfer with div_waddr==0 SHALL be accepted and discarded (no write, buffer not loaded).
REQ-022 Stale-drop: when the pipeline is granted with pipe_waddr equal to buf_addr (buffer valid) or equal to div_waddr of a same-cycle transfer, that divider entry SHALL be discarded and never written.
REQ-023 wait_cnt SHALL increment (saturating at STARVE_MAX) each cycle the buffer is valid and not granted, and clear when the buffer is granted, discarded, or empty.
REQ-024 Buffer grant clears buf_valid; a new divider transfer in the same cycle is not possible (div_ready was 0).
REQ-025 rd_stall = buf_valid && buf_addr!=0 && ((re1 && raddr1==buf_addr) || (re2 && raddr2==buf_addr)), combinational.
REQ-026 Pipeline writes with pipe_waddr==0 SHALL be treated as no request.

Reset
REQ-027 While rst==0: we=0, waddr=0, wdata=0, buf_valid=0, buf_addr=0, buf_data=0, wait_cnt=0, pipe_hold=0, rd_stall=0, div_ready=0.
REQ-028 Reset asserted mid-operation SHALL discard any buffered entry; no write is issued after rst rises until a new grant.

Configuration
REQ-029 Macro WB_ARB_STAT_EN: when defined, add outputs drop_cnt[15:0] (stale-drop count) and force_cnt[15:0] (forced-grant count), each saturating at 16'hFFFF, cleared by reset; when undefined these outputs and counters SHALL not exist and behaviour is otherwise identical.

Verification
REQ-030 Bypass: idle pipe, div_valid=1, div_waddr=5, div_wdata=32'h1234 -> next cycle we=1, waddr=5, wdata=32'h1234; buffer remains empty.
REQ-031 Buffering: pipe_we=1 waddr=3 with div transfer waddr=7 -> cycle+1 writes r3; pipe idle next -> cycle+2 writes r7; div_ready=0 in between; rd_stall=1 for raddr1=7, re1=1 while buffered.
REQ-032 Starvation: STARVE_MAX=4, buffered r9, pipe_we=1 continuously to r2 -> pipe_hold=1 in the 5th cycle, r9 written the following cycle, pipe write r2 issued after hold.
REQ-033 Stale-drop: buffered r4=32'hAAAA, pipeline writes r4=32'hBBBB -> only 32'hBBBB written; buffer clears; drop_cnt=1 when WB_ARB_STAT_EN defined.
REQ-034 Reset: buffered r6, assert rst=0 asynchronously mid-cycle -> all outputs 0 immediately; after release no write to r6 occurs.
REQ-035 Zero address: div transfer waddr=0 and pipe_we=1 waddr=0 -> we stays 0, div_ready stays 1.
